// File: rtl/fmap_streamer_if.sv
// fmap_streamer_if: memory read port and pixel stream handshake of fmap_streamer.
// master = streamer side, slave = memory model / line-buffer side.
interface fmap_streamer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 24
) ();
    // Memory read port: data returns exactly one cycle after mem_rd_en.
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;

    // Pixel stream towards the counterGroup line-buffer front end.
    logic              valid_o;
    logic [DATA_W-1:0] pixel_o;
    logic              ready_i;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output valid_o,
        output pixel_o,
        input  ready_i
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  valid_o,
        input  pixel_o,
        output ready_i
    );
endinterface

// File: rtl/fmap_streamer.sv
// fmap_streamer: reads chnl_num channels of IMG_DIM x IMG_DIM pixels from a one-cycle-latency
// memory starting at base_addr and streams them through a 2-entry FIFO with valid/ready.
// Optional feature macro: STREAM_FLUSH_EN -- when defined, FLUSH_LEN zero pixels are appended
// after the last channel; when undefined the job ends right after the last real pixel.
module fmap_streamer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned IMG_DIM   = 112,
    parameter int unsigned FLUSH_LEN = 113
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        chnl_num,
    input  logic [ADDR_W-1:0] base_addr,
    fmap_streamer_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic [9:0]        chnl_idx
);

    localparam int unsigned PixPerChnl = IMG_DIM * IMG_DIM;
    localparam int unsigned PixW       = $clog2(PixPerChnl + 1);
    localparam int unsigned FlushW     = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;

    localparam logic [PixW-1:0]   PixLast   = PixW'(PixPerChnl - 1);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StDrain
    } state_e;

    // State entered once the final memory read has been issued.
`ifdef STREAM_FLUSH_EN
    localparam state_e StPostStream = (FLUSH_LEN > 0) ? StFlush : StDrain;
`else
    localparam state_e StPostStream = StDrain;
`endif

    // FSM and job bookkeeping.
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [9:0]        chnl_idx_q, chnl_idx_d;
    logic [9:0]        chnl_last_q, chnl_last_d;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic              done_q, done_d;
    logic              inflight_q;

    // 2-entry pixel FIFO.
    logic [DATA_W-1:0] fifo_mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q, count_d;

    // Datapath control.
    logic              pop;
    logic              push;
    logic              push_zero;
    logic [DATA_W-1:0] push_data;
    logic [2:0]        occupancy;
    logic              rd_issue;
    logic              drain_done;

    // FIFO handshake and read-issue gating.
    always_comb begin
        pop       = (count_q != 2'd0) && bus.ready_i;
        // A slot freed by this cycle's pop is already usable, which is what allows one read
        // per cycle with only two entries of storage.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_issue  = (state_q == StStream) && (occupancy < 3'd2);
        // Zeros may only enter once the last real pixel has landed, keeping stream order.
        push_zero = (state_q == StFlush) && !inflight_q && (count_q < 2'd2);
        push      = inflight_q || push_zero;
        push_data = push_zero ? '0 : bus.mem_rd_data;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        drain_done = !inflight_q &&
                     ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Read-in-flight flag; clearing it on reset discards any data still on its way back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
        end
    end

    // Next-state logic: job launch, address/channel sequencing, flush count and completion.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pix_cnt_d   = pix_cnt_q;
        chnl_idx_d  = chnl_idx_q;
        chnl_last_d = chnl_last_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                // A start landing on the done cycle belongs to the finished job; drop it.
                if (start && !done_q) begin
                    state_d     = StStream;
                    addr_d      = base_addr;
                    pix_cnt_d   = '0;
                    chnl_idx_d  = 10'd0;
                    chnl_last_d = (chnl_num == 10'd0) ? 10'd0 : chnl_num - 10'd1;
                    flush_cnt_d = '0;
                end
            end

            StStream: begin
                if (rd_issue) begin
                    addr_d = addr_q + 1'b1;
                    if (pix_cnt_q == PixLast) begin
                        pix_cnt_d = '0;
                        // The last channel index is held rather than stepped past.
                        if (chnl_idx_q == chnl_last_q) begin
                            state_d = StPostStream;
                        end else begin
                            chnl_idx_d = chnl_idx_q + 10'd1;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end

            StFlush: begin
                if (push_zero) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == FlushLast) begin
                        state_d = StDrain;
                    end
                end
            end

            StDrain: begin
                if (drain_done) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            pix_cnt_q   <= '0;
            chnl_idx_q  <= 10'd0;
            chnl_last_q <= 10'd0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pix_cnt_q   <= pix_cnt_d;
            chnl_idx_q  <= chnl_idx_d;
            chnl_last_q <= chnl_last_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
        end
    end

    assign bus.mem_rd_en = rd_issue;
    assign bus.mem_addr  = addr_q;
    assign bus.valid_o   = (count_q != 2'd0);
    assign bus.pixel_o   = fifo_mem_q[rd_ptr_q];
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign chnl_idx      = chnl_idx_q;

    // Storage invariants: never more than two entries, never a push into a full FIFO.
    a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fmap_streamer.sv
// tb_fmap_streamer: scoreboard bench for fmap_streamer. Image size is scaled down so every
// scenario (nominal, back-pressure, re-start, mid-job reset, address wrap) fits a short run.
module tb_fmap_streamer;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 24;
    localparam int IMG_DIM   = 16;
    localparam int FLUSH_LEN = 17;
    localparam int PIX       = IMG_DIM * IMG_DIM;
`ifdef STREAM_FLUSH_EN
    localparam int FLUSH_EXP = FLUSH_LEN;
`else
    localparam int FLUSH_EXP = 0;
`endif
    localparam int BUDGET = 4 * (2 * PIX + FLUSH_EXP) + 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [9:0]        chnl_num;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic [9:0]        chnl_idx;

    fmap_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

    fmap_streamer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .IMG_DIM  (IMG_DIM),
        .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .chnl_num (chnl_num),
        .base_addr(base_addr),
        .bus      (sif.master),
        .busy     (busy),
        .done     (done),
        .chnl_idx (chnl_idx)
    );

    always #5 clk = ~clk;

    // Memory model: data is the low byte of the address, one cycle after the request.
    always @(posedge clk) begin
        if (sif.mem_rd_en) sif.mem_rd_data <= sif.mem_addr[7:0];
    end

    int errors = 0;
    int checks = 0;

    logic [7:0]        sb_pix[$];
    logic [ADDR_W-1:0] sb_addr[$];

    logic              o_valid, o_rdy, o_rd, o_done, o_busy;
    logic [7:0]        o_pix;
    logic [ADDR_W-1:0] o_addr;
    logic [9:0]        o_idx;
    logic              beat, pix_miss, addr_miss;
    logic [7:0]        exp_pix;
    logic [ADDR_W-1:0] exp_addr;
    logic [9:0]        exp_idx;
    int                nbeats, ndone, nreads, job_chn;
    bit                rnd_ready, start_on_done;

    // Drive a start pulse and load the scoreboard with the expected reads and pixels.
    task automatic launch(input logic [9:0] chn, input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] a;
        int n;
        chnl_num  = chn;
        base_addr = base;
        start     = 1'b1;
        job_chn   = (chn == 10'd0) ? 1 : int'(chn);
        n         = job_chn * PIX;
        for (int k = 0; k < n; k++) begin
            a = base + ADDR_W'(k);
            sb_addr.push_back(a);
            sb_pix.push_back(a[7:0]);
        end
        for (int k = 0; k < FLUSH_EXP; k++) sb_pix.push_back(8'h00);
        nbeats = 0;
        ndone  = 0;
        nreads = 0;
    endtask

    // One clock: sample at the falling edge, pop the scoreboard, then drive after the rise.
    task automatic tick();
        int q;
        @(negedge clk);
        o_valid = sif.valid_o;
        o_rdy   = sif.ready_i;
        o_pix   = sif.pixel_o;
        o_rd    = sif.mem_rd_en;
        o_addr  = sif.mem_addr;
        o_done  = done;
        o_busy  = busy;
        o_idx   = chnl_idx;
        beat    = o_valid && o_rdy;
        q = nreads / PIX;
        if (q > job_chn - 1) q = job_chn - 1;
        exp_idx   = 10'(q);
        pix_miss  = 1'b0;
        addr_miss = 1'b0;
        if (beat) begin
            nbeats++;
            if (sb_pix.size() == 0) pix_miss = 1'b1;
            else exp_pix = sb_pix.pop_front();
        end
        if (o_rd) begin
            nreads++;
            if (sb_addr.size() == 0) addr_miss = 1'b1;
            else exp_addr = sb_addr.pop_front();
        end
        if (o_done) ndone++;
        if (o_done && start_on_done) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sif.ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        chnl_num = 10'd0;
        base_addr = '0;
        sif.ready_i = 1'b1;
        job_chn = 1;
        repeat (3) tick();
        checks++;
        if ({o_valid, o_rd, o_busy, o_done, o_pix, o_addr, o_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b rd=%b busy=%b done=%b pix=%h addr=%h idx=%0d want 0",
                     o_valid, o_rd, o_busy, o_done, o_pix, o_addr, o_idx);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
    endtask

    // Nominal job with ready held high: order, latency, throughput, done, start-on-done.
    task automatic test_stream();
        int n_exp, t, first_t, done_t;
        logic prev_busy;
        rnd_ready = 0;
        start_on_done = 1;
        launch(10'd2, 24'h000100);
        n_exp = 2 * PIX + FLUSH_EXP;
        first_t = -1;
        done_t = -1;
        prev_busy = 1'b0;
        t = 0;
        while (t < BUDGET && done_t < 0) begin
            t++;
            tick();
            if (o_valid && first_t < 0) first_t = t;
            if (beat) begin
                checks++;
                if (pix_miss || o_pix !== exp_pix) begin
                    errors++;
                    $display("FAIL stream_pixel beat %0d got %h want %h", nbeats, o_pix, exp_pix);
                end
            end
            if (o_rd) begin
                checks++;
                if (addr_miss || o_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL stream_addr read %0d got %h want %h", nreads, o_addr, exp_addr);
                end
            end
            if (o_busy) begin
                checks++;
                if (o_idx !== exp_idx) begin
                    errors++;
                    $display("FAIL stream_chnl_idx reads %0d got %0d want %0d", nreads, o_idx, exp_idx);
                end
            end
            if (o_done) begin
                done_t = t;
                checks++;
                if (o_busy !== 1'b0 || prev_busy !== 1'b1 || o_idx !== 10'd1) begin
                    errors++;
                    $display("FAIL stream_done_edge got busy=%b prev=%b idx=%0d want 0 1 1",
                             o_busy, prev_busy, o_idx);
                end
            end
            prev_busy = o_busy;
        end
        checks++;
        if (done_t < 0) begin
            errors++;
            $display("FAIL stream_timeout got no done in %0d cycles want done", BUDGET);
        end
        // Sample 1 precedes the accepting edge, so sample 4 is two edges after it.
        checks++;
        if (first_t != 4) begin
            errors++;
            $display("FAIL stream_latency got first valid at sample %0d want 4", first_t);
        end
        checks++;
        if (done_t - first_t != n_exp) begin
            errors++;
            $display("FAIL stream_throughput got %0d cycles want %0d", done_t - first_t, n_exp);
        end
        checks++;
        if (nbeats != n_exp || sb_pix.size() != 0) begin
            errors++;
            $display("FAIL stream_beats got %0d left %0d want %0d left 0", nbeats, sb_pix.size(), n_exp);
        end
        repeat (4) tick();
        start_on_done = 0;
        checks++;
        if (ndone != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_done got done=%0d busy=%b want 1 0", ndone, o_busy);
        end
    endtask

    // Random 50% ready: same sequence, stable pixel while stalled, FIFO bound.
    task automatic test_back_pressure();
        int n_exp, t;
        logic pv_valid, pv_rdy;
        logic [7:0] pv_pix;
        rnd_ready = 1;
        launch(10'd2, 24'h000100);
        n_exp = 2 * PIX + FLUSH_EXP;
        pv_valid = 1'b0;
        pv_rdy = 1'b1;
        pv_pix = '0;
        t = 0;
        while (t < BUDGET && ndone == 0) begin
            t++;
            tick();
            if (beat) begin
                checks++;
                if (pix_miss || o_pix !== exp_pix) begin
                    errors++;
                    $display("FAIL bp_pixel beat %0d got %h want %h", nbeats, o_pix, exp_pix);
                end
            end
            if (o_rd) begin
                checks++;
                if (addr_miss || o_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL bp_addr read %0d got %h want %h", nreads, o_addr, exp_addr);
                end
            end
            if (pv_valid && !pv_rdy) begin
                checks++;
                if (o_valid !== 1'b1 || o_pix !== pv_pix) begin
                    errors++;
                    $display("FAIL bp_stall got v=%b pix=%h want 1 %h", o_valid, o_pix, pv_pix);
                end
            end
            checks++;
            if (dut.count_q > 2'd2) begin
                errors++;
                $display("FAIL bp_fifo_count got %0d want <=2", dut.count_q);
            end
            pv_valid = o_valid;
            pv_rdy = o_rdy;
            pv_pix = o_pix;
        end
        rnd_ready = 0;
        checks++;
        if (ndone != 1 || nbeats != n_exp || sb_pix.size() != 0) begin
            errors++;
            $display("FAIL bp_total got done=%0d beats=%0d want 1 %0d", ndone, nbeats, n_exp);
        end
    endtask

    // A second start mid-job is ignored.
    task automatic test_restart();
        int n_exp, t;
        bit fired;
        rnd_ready = 0;
        launch(10'd2, 24'h000100);
        n_exp = 2 * PIX + FLUSH_EXP;
        fired = 0;
        t = 0;
        while (t < BUDGET && ndone == 0) begin
            t++;
            tick();
            if (beat) begin
                checks++;
                if (pix_miss || o_pix !== exp_pix) begin
                    errors++;
                    $display("FAIL restart_pixel beat %0d got %h want %h", nbeats, o_pix, exp_pix);
                end
            end
            if (nbeats == 100 && !fired) begin
                fired = 1;
                chnl_num = 10'd5;
                base_addr = 24'h00ABCD;
                start = 1'b1;
            end
        end
        repeat (3) tick();
        checks++;
        if (ndone != 1 || nbeats != n_exp || sb_pix.size() != 0) begin
            errors++;
            $display("FAIL restart_total got done=%0d beats=%0d want 1 %0d", ndone, nbeats, n_exp);
        end
    endtask

    // Reset mid-job aborts silently; the next job streams cleanly from base_addr.
    task automatic test_reset_mid_job();
        int n_exp, t;
        rnd_ready = 0;
        launch(10'd2, 24'h000100);
        t = 0;
        while (t < BUDGET && nbeats < 300) begin
            t++;
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({o_valid, o_rd, o_busy, o_done, o_pix, o_addr, o_idx} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b rd=%b busy=%b done=%b pix=%h addr=%h idx=%0d want 0",
                     o_valid, o_rd, o_busy, o_done, o_pix, o_addr, o_idx);
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL midrst_no_done got %0d want 0", ndone);
        end
        rst = 1'b0;
        sb_pix.delete();
        sb_addr.delete();
        tick();
        launch(10'd1, 24'h000100);
        n_exp = PIX + FLUSH_EXP;
        t = 0;
        while (t < BUDGET && ndone == 0) begin
            t++;
            tick();
            if (beat) begin
                checks++;
                if (pix_miss || o_pix !== exp_pix) begin
                    errors++;
                    $display("FAIL midrst_pixel beat %0d got %h want %h", nbeats, o_pix, exp_pix);
                end
            end
            if (o_rd) begin
                checks++;
                if (addr_miss || o_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL midrst_addr read %0d got %h want %h", nreads, o_addr, exp_addr);
                end
            end
        end
        checks++;
        if (ndone != 1 || nbeats != n_exp || sb_pix.size() != 0) begin
            errors++;
            $display("FAIL midrst_total got done=%0d beats=%0d want 1 %0d", ndone, nbeats, n_exp);
        end
    endtask

    // chnl_num=0 acts as one channel; addresses wrap through zero.
    task automatic test_wrap();
        int n_exp, t;
        bit saw_zero;
        rnd_ready = 0;
        launch(10'd0, 24'hFFFFF0);
        n_exp = PIX + FLUSH_EXP;
        saw_zero = 0;
        t = 0;
        while (t < BUDGET && ndone == 0) begin
            t++;
            tick();
            if (beat) begin
                checks++;
                if (pix_miss || o_pix !== exp_pix) begin
                    errors++;
                    $display("FAIL wrap_pixel beat %0d got %h want %h", nbeats, o_pix, exp_pix);
                end
            end
            if (o_rd) begin
                if (o_addr == '0) saw_zero = 1;
                checks++;
                if (addr_miss || o_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL wrap_addr read %0d got %h want %h", nreads, o_addr, exp_addr);
                end
            end
            if (o_busy) begin
                checks++;
                if (o_idx !== 10'd0) begin
                    errors++;
                    $display("FAIL wrap_chnl_idx got %0d want 0", o_idx);
                end
            end
        end
        checks++;
        if (!saw_zero || nreads != PIX) begin
            errors++;
            $display("FAIL wrap_reads got zero_seen=%0d reads=%0d want 1 %0d", saw_zero, nreads, PIX);
        end
        checks++;
        if (ndone != 1 || nbeats != n_exp || sb_pix.size() != 0) begin
            errors++;
            $display("FAIL wrap_total got done=%0d beats=%0d want 1 %0d", ndone, nbeats, n_exp);
        end
    endtask

    initial begin
        rnd_ready = 0;
        start_on_done = 0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_restart();
        test_reset_mid_job();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fmap_streamer.md
FMAP_STREAMER -- requirements
Module: fmap_streamer

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, pixel width.
REQ-002 The block SHALL expose parameter ADDR_W, default 24, memory address width.
REQ-003 The block SHALL expose parameter IMG_DIM, default 112, image rows and columns per channel.
REQ-004 The block SHALL expose parameter FLUSH_LEN, default 113, zero pixels appended after the last channel.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset: clk in 1, clock (rising edge); rst in 1, reset.
REQ-006 start  in  1  pulse; launches one job when idle.
REQ-007 chnl_num  in  10  channel count, latched on accepted start; 0 treated as 1.
REQ-008 base_addr  in  ADDR_W  address of pixel (row 0, col 0, channel 0), latched on accepted start.
REQ-009 mem_rd_en / mem_addr  out  1 / ADDR_W  read request; mem_rd_data  in  DATA_W  returned exactly 1 cycle after mem_rd_en.
REQ-010 valid_o / pixel_o  out  1 / DATA_W  pixel stream to the counterGroup line-buffer front end; ready_i  in  1  downstream accept.
REQ-011 busy  out  1  job active; done  out  1  one-cycle completion pulse; chnl_idx  out  10  channel currently being read.

Function
REQ-012 A beat SHALL transfer when valid_o and ready_i are both high; pixel_o SHALL be stable while valid_o is high and ready_i is low.
REQ-013 The FSM SHALL use states IDLE, STREAM, FLUSH, DRAIN: IDLE->STREAM on start; STREAM->FLUSH after the last read is issued; FLUSH->DRAIN after FLUSH_LEN zero pixels are enqueued; DRAIN->IDLE when the FIFO is empty and no read is in flight.
REQ-014 Pixels SHALL pass through a 2-entry FIFO; valid_o = FIFO non-empty; pixel_o = FIFO head.
REQ-015 A read SHALL be issued only when (FIFO count + reads in flight) < 2, so no data is ever dropped under back-pressure.
REQ-016 Read addresses SHALL be base_addr + k for k = 0 .. chnl_num*IMG_DIM*IMG_DIM-1, strictly increasing by 1; the arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-017 chnl_idx SHALL increment after every IMG_DIM*IMG_DIM reads and hold its final value through FLUSH and DRAIN.
REQ-018 In FLUSH, a zero pixel SHALL be pushed only when no read is in flight and the FIFO count is < 2, preserving stream order.
REQ-019 done SHALL pulse in the cycle after the final beat transfers, coincident with busy falling.
REQ-020 start while busy SHALL be ignored; start together with done SHALL be ignored.
REQ-021 Sustained throughput SHALL be 1 beat per cycle with ready_i held high; first valid_o SHALL occur 2 cycles after start.

Reset
REQ-022 rst SHALL force IDLE, empty the FIFO, clear the in-flight flag, and drive valid_o=0, pixel_o=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, chnl_idx=0.
REQ-023 rst mid-job SHALL abort the job without a done pulse; read data returning after rst deasserts SHALL be discarded.

Configuration
REQ-024 With STREAM_FLUSH_EN defined, FLUSH SHALL run as specified; without it, STREAM SHALL go directly to DRAIN and no zero pixels SHALL be emitted.

Verification
REQ-025 chnl_num=2, base_addr=0x000100, mem_rd_data=addr[7:0], ready_i=1 -> 25088 beats with data 0x00,0x01,... in order, then 113 zero beats (25201 total), then a done pulse; chnl_idx=1 after read 12544.
REQ-026 Same job with ready_i toggling at random, 50% duty -> identical beat sequence, no drops or duplicates, FIFO count never exceeds 2, pixel_o stable while stalled.
REQ-027 start pulsed again at beat 500 -> ignored; total beats remain 25201 and exactly one done pulse occurs.
REQ-028 rst asserted at beat 3000 -> all outputs at reset values next cycle, no done pulse; a new start then produces a clean stream starting at base_addr.
REQ-029 chnl_num=0, base_addr=0xFFFFF0 -> 12544 reads wrapping through 0x000000, then 113 zeros.
REQ-030 Built without STREAM_FLUSH_EN, chnl_num=1 -> exactly 12544 beats, then done.
